rc522_reg_access: RTL and testbench

RC522_REG_ACCESS -- requirements
Module: rc522_reg_access

---
 rtl/rc522_reg_access_if.sv | 38 +++
 rtl/rc522_reg_access.sv | 146 ++++++++++++++
 tb/tb_rc522_reg_access.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rc522_reg_access_if.sv
// Host and SPI byte-engine signals for rc522_reg_access.
// err is present only when RC522_TIMEOUT_EN is defined.
interface rc522_reg_access_if;
    logic       req;
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
`ifdef RC522_TIMEOUT_EN
    logic       err;
`endif
    logic       spi_start;
    logic [7:0] spi_tx;
    logic [7:0] spi_rx;
    logic       spi_done;

`ifdef RC522_TIMEOUT_EN
    modport master (
        output req, we, addr, wdata, spi_rx, spi_done,
        input  rdata, busy, done, err, spi_start, spi_tx
    );
    modport slave (
        input  req, we, addr, wdata, spi_rx, spi_done,
        output rdata, busy, done, err, spi_start, spi_tx
    );
`else
    modport master (
        output req, we, addr, wdata, spi_rx, spi_done,
        input  rdata, busy, done, spi_start, spi_tx
    );
    modport slave (
        input  req, we, addr, wdata, spi_rx, spi_done,
        output rdata, busy, done, spi_start, spi_tx
    );
`endif
endinterface

// File: rtl/rc522_reg_access.sv
// Two-byte SPI register read/write sequencer for the RC522 (address byte, gap, data byte).
// Define RC522_TIMEOUT_EN to add a per-byte completion timeout with an err pulse.
module rc522_reg_access #(
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    rc522_reg_access_if.slave bus
);
    localparam int unsigned   GW       = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);

    // A zero timeout would fire before any byte could ever complete.
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    typedef enum logic [2:0] {
        IDLE,
        A_START,
        A_WAIT,
        GAP,
        D_START,
        D_WAIT,
        FINISH
    } state_t;

    state_t        state;
    logic          we_q;
    logic [7:0]    wdata_q;
    logic [GW-1:0] gap_cnt;
    logic          spi_done_q;
    logic          spi_rise;

`ifdef RC522_TIMEOUT_EN
    localparam int unsigned   TW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_cnt;
`endif

    // Only a fresh rising edge counts; a level left high by the previous byte is ignored.
    always_comb begin
        spi_rise = bus.spi_done & ~spi_done_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            gap_cnt       <= '0;
            spi_done_q    <= 1'b0;
            bus.spi_start <= 1'b0;
            bus.spi_tx    <= '0;
            bus.rdata     <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
`ifdef RC522_TIMEOUT_EN
            bus.err       <= 1'b0;
            tmo_cnt       <= '0;
`endif
        end else begin
            spi_done_q    <= bus.spi_done;
            bus.spi_start <= 1'b0;
            bus.done      <= 1'b0;
`ifdef RC522_TIMEOUT_EN
            bus.err       <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (bus.req) begin
                        we_q          <= bus.we;
                        wdata_q       <= bus.wdata;
                        bus.spi_tx    <= {~bus.we, bus.addr, 1'b0};
                        bus.spi_start <= 1'b1;
                        bus.busy      <= 1'b1;
                        state         <= A_START;
                    end
                end
                A_START: begin
`ifdef RC522_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state <= A_WAIT;
                end
                A_WAIT: begin
                    if (spi_rise) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
`ifdef RC522_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        bus.err  <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                // GAP occupies GAP_CYCLES+1 cycles: the count plus the cycle that launches the data byte.
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        bus.spi_tx    <= we_q ? wdata_q : 8'h00;
                        bus.spi_start <= 1'b1;
                        state         <= D_START;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                D_START: begin
`ifdef RC522_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state <= D_WAIT;
                end
                D_WAIT: begin
                    if (spi_rise) begin
                        if (!we_q) begin
                            bus.rdata <= bus.spi_rx;
                        end
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= FINISH;
                    end
`ifdef RC522_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        bus.err  <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rc522_reg_access.sv
// Bench for rc522_reg_access: behavioural SPI byte engine plus directed and random transactions.
// Timeout checks are included when RC522_TIMEOUT_EN is defined.
module tb_rc522_reg_access;
    logic clk = 1'b0;
    logic rst = 1'b1;

    rc522_reg_access_if bus();

    rc522_reg_access #(
        .GAP_CYCLES    (2),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Engine controls written by the stimulus block.
    int         eng_t    = 4;
    int         eng_d    = 0;
    bit         eng_hang = 1'b0;
    logic [7:0] eng_rx   = 8'h00;

    // Engine-private state and observations.
    int         eng_cnt     = 0;
    int         eng_clr     = 0;
    int         n_start     = 0;
    int         tx_unstable = 0;
    logic [7:0] cur_tx      = 8'h00;
    logic [7:0] tx_log[$];

    logic [7:0] exp_rdata = 8'h00;

    // SPI byte engine: byte takes eng_t cycles, optionally leaves the old done level up for eng_d cycles.
    always @(negedge clk) begin
        if (rst) begin
            eng_cnt      = 0;
            eng_clr      = 0;
            bus.spi_done = 1'b0;
            bus.spi_rx   = 8'h00;
        end else if (bus.spi_start) begin
            n_start++;
            tx_log.push_back(bus.spi_tx);
            cur_tx  = bus.spi_tx;
            eng_cnt = eng_hang ? 0 : eng_t;
            eng_clr = eng_hang ? 0 : eng_d;
            if (eng_clr == 0) bus.spi_done = 1'b0;
        end else begin
            if (eng_clr > 0) begin
                eng_clr--;
                if (eng_clr == 0) bus.spi_done = 1'b0;
            end
            if (eng_cnt > 0) begin
                if (bus.spi_tx !== cur_tx) tx_unstable++;
                eng_cnt--;
                if (eng_cnt == 0) begin
                    bus.spi_done = 1'b1;
                    bus.spi_rx   = eng_rx;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one transaction starting at the current negedge; returns in the cycle after done.
    task automatic run_txn(input logic w, input logic [5:0] a, input logic [7:0] wd,
                           input logic [7:0] rx, input int t, input int d, input logic glitch);
        int         bs, bt, bu, lat;
        logic       seen, busy_ok;
        logic [7:0] e0, e1, g0, g1;
        e0 = 8'((w ? 0 : 128) + 2 * int'(a));
        e1 = w ? wd : 8'h00;
        eng_t  = t;
        eng_d  = d;
        eng_rx = 8'($urandom);
        bs = n_start;
        bt = tx_log.size();
        bu = tx_unstable;
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = wd;
        @(negedge clk);
        bus.req   = 1'b0;
        bus.we    = ~w;
        bus.addr  = ~a;
        bus.wdata = ~wd;
        lat = 1;
        seen = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (!bus.busy) busy_ok = 1'b0;
                if (n_start - bs >= 2) eng_rx = rx;
                bus.req = (glitch && i == 2) ? 1'b1 : 1'b0;
                @(negedge clk);
                lat++;
            end
        end
        bus.req = 1'b0;
        check("txn_done_seen", 32'(seen), 1);
        check("txn_latency_window", 32'(lat >= 2 * t + 6 && lat <= 2 * t + 8), 1);
        check("txn_busy_while_pending", 32'(busy_ok), 1);
        check("txn_busy_low_at_done", 32'(bus.busy), 0);
        g0 = (tx_log.size() > bt)     ? tx_log[bt]     : 8'hxx;
        g1 = (tx_log.size() > bt + 1) ? tx_log[bt + 1] : 8'hxx;
        check("txn_tx_addr_byte", 32'(g0), 32'(e0));
        check("txn_tx_second_byte", 32'(g1), 32'(e1));
        check("txn_tx_stable", 32'(tx_unstable - bu), 0);
        if (!w) exp_rdata = rx;
        check("txn_rdata", 32'(bus.rdata), 32'(exp_rdata));
        @(negedge clk);
        check("txn_done_one_cycle", 32'(bus.done), 0);
        check("txn_spi_start_count", 32'(n_start - bs), 2);
    endtask

    initial begin
        int         base, dn, t, d, lat;
        logic       seen;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (3) @(negedge clk);

        check("reset_rdata", 32'(bus.rdata), 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_spi_start", 32'(bus.spi_start), 0);
        check("reset_spi_tx", 32'(bus.spi_tx), 0);
`ifdef RC522_TIMEOUT_EN
        check("reset_err", 32'(bus.err), 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Directed write and read, then a stale done level and a req during busy.
        run_txn(1'b1, 6'h01, 8'h0F, 8'hA5, 4, 0, 1'b0);
        check("write_rdata_unchanged", 32'(bus.rdata), 0);
        run_txn(1'b0, 6'h37, 8'h00, 8'h92, 4, 0, 1'b0);
        check("read_37_rdata", 32'(bus.rdata), 32'h92);
        run_txn(1'b1, 6'h11, 8'h3C, 8'h00, 5, 3, 1'b0);
        run_txn(1'b0, 6'h22, 8'h00, 8'h4D, 3, 0, 1'b1);
        run_txn(1'b1, 6'h23, 8'h81, 8'h19, 3, 0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            t = int'($urandom_range(6, 2));
            d = int'($urandom_range(t - 1, 0));
            run_txn(1'($urandom_range(1, 0)), 6'($urandom), 8'($urandom), 8'($urandom),
                    t, d, 1'($urandom_range(1, 0)));
        end

        // Reset while the data byte is in flight.
        run_txn(1'b0, 6'h05, 8'h00, 8'hC3, 3, 0, 1'b0);
        eng_t = 6;
        eng_d = 0;
        base = n_start;
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 6'h2A;
        @(negedge clk);
        bus.req = 1'b0;
        for (int i = 0; i < 100 && (n_start - base) < 2; i++) @(negedge clk);
        check("rst_reached_data_byte", 32'(n_start - base), 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(bus.busy), 0);
        check("rst_mid_done", 32'(bus.done), 0);
        check("rst_mid_spi_start", 32'(bus.spi_start), 0);
        check("rst_mid_spi_tx", 32'(bus.spi_tx), 0);
        check("rst_mid_rdata", 32'(bus.rdata), 0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        rst = 1'b0;
        exp_rdata = 8'h00;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("rst_no_done", 32'(dn), 0);
        run_txn(1'b0, 6'h2A, 8'h00, 8'h6E, 4, 0, 1'b0);

`ifdef RC522_TIMEOUT_EN
        // Engine never completes: err 64 cycles after entering A_WAIT.
        eng_hang = 1'b1;
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 6'h0A;
        bus.wdata = 8'h77;
        @(negedge clk);
        bus.req = 1'b0;
        lat = 1;
        seen = 1'b0;
        dn = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (bus.err) begin
                seen = 1'b1;
            end else begin
                if (bus.done) dn++;
                @(negedge clk);
                lat++;
            end
        end
        check("tmo_err_seen", 32'(seen), 1);
        check("tmo_latency", 32'(lat), 64 + 2);
        check("tmo_busy_low", 32'(bus.busy), 0);
        check("tmo_rdata_unchanged", 32'(bus.rdata), 32'(exp_rdata));
        @(negedge clk);
        check("tmo_err_one_cycle", 32'(bus.err), 0);
        check("tmo_no_done", 32'(dn + int'(bus.done)), 0);
        eng_hang = 1'b0;
        run_txn(1'b0, 6'h0B, 8'h00, 8'hB4, 3, 0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
